// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller:
// segment encodings, the blanked pattern and the scan state type.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } scan_state_t;

  // Active-high segments, bit6=a ... bit0=g
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h00;
    unique case (v)
      4'h0: s = 7'h7E;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h79;
      4'h4: s = 7'h33;
      4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h7B;
      4'hA: s = 7'h77;
      4'hB: s = 7'h1F;
      4'hC: s = 7'h0E;
      4'hD: s = 7'h3D;
      4'hE: s = 7'h4F;
      4'hF: s = 7'h47;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex7seg_lut.sv
// Hex nibble to active-low 7-segment pattern.
// One instance is shared by every scanned digit.
module hex7seg_lut
  import seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = ~hex_to_seg(hex_i);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scanner with a double-buffered frame
// and an all-off gap ahead of every digit slot.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DIV        = 50000,
  parameter int BLANK      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   wr_mask,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);

  localparam int MAXC = (DIV > BLANK) ? DIV : BLANK;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int DW   = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  scan_state_t           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  wrap;

  logic [DW-1:0]         act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0] act_mask_q, act_mask_d;
  logic [DW-1:0]         pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0] pend_mask_q, pend_mask_d;
  logic                  pend_full_q, pend_full_d;
  logic                  wr_fire;

  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
  logic                  wr_ready_q;
  logic                  frame_done_q;

  logic                  lit;
  logic [3:0]            nib;
  logic [6:0]            lut_seg;

  assign seg        = seg_q;
  assign dig_sel    = dig_sel_q;
  assign wr_ready   = wr_ready_q;
  assign frame_done = frame_done_q;
  assign wr_fire    = wr_valid && wr_ready_q;

  // Slot timer: BLANK gap, then DIV lit cycles, then next digit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wrap    = 1'b0;
    unique case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHOW: begin
        if (cnt_q == DIV_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Pending buffer fill and swap into active at frame boundary
  always_comb begin
    act_data_d  = act_data_q;
    act_mask_d  = act_mask_q;
    pend_data_d = pend_data_q;
    pend_mask_d = pend_mask_q;
    pend_full_d = pend_full_q;
    if (frame_done_q && pend_full_q) begin
      act_data_d  = pend_data_q;
      act_mask_d  = pend_mask_q;
      pend_full_d = 1'b0;
    end
    if (wr_fire) begin
      pend_data_d = wr_data;
      pend_mask_d = wr_mask;
      pend_full_d = 1'b1;
    end
  end

  // Outputs follow next state so the register matches the slot
  always_comb begin
    lit = (state_d == ST_SHOW) && !act_mask_d[idx_d];
    nib = act_data_d[{idx_d, 2'b00} +: 4];
    seg_d = SEG_OFF;
    dig_sel_d = '1;
    if (lit) begin
      seg_d     = lut_seg;
      dig_sel_d = ~(NUM_DIGITS'(1) << idx_d);
    end
  end

  hex7seg_lut u_lut (
    .hex_i   (nib),
    .seg_n_o (lut_seg)
  );

  // State, buffers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      act_data_q   <= '0;
      act_mask_q   <= '1;
      pend_data_q  <= '0;
      pend_mask_q  <= '0;
      pend_full_q  <= 1'b0;
      seg_q        <= SEG_OFF;
      dig_sel_q    <= '1;
      wr_ready_q   <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_data_q   <= act_data_d;
      act_mask_q   <= act_mask_d;
      pend_data_q  <= pend_data_d;
      pend_mask_q  <= pend_mask_d;
      pend_full_q  <= pend_full_d;
      seg_q        <= seg_d;
      dig_sel_q    <= dig_sel_d;
      wr_ready_q   <= !pend_full_d;
      frame_done_q <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with 4 digits, DIV=4, BLANK=2
// (slot 6 cycles, frame 24 cycles).
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_data = '0;
  logic [3:0]  wr_mask = '0;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;
  logic        frame_done;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS (4),
    .DIV        (4),
    .BLANK      (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_mask    (wr_mask),
    .seg        (seg),
    .dig_sel    (dig_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // cycle 0 = first period after the last edge that saw rst high
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic wait_cyc(input int n);
    int g;
    g = 0;
    while (cyc != n && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (cyc != n) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_cyc: at cycle %0d, required %0d", cyc, n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if (seg !== 7'h7F) begin
      n_fail++;
      $display("FAIL reset_seg: got %h want 7f", seg);
    end
    n_chk++;
    if (dig_sel !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_dig: got %h want f", dig_sel);
    end
    n_chk++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", wr_ready);
    end
    n_chk++;
    if (frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fd: got %b want 0", frame_done);
    end
  endtask

  task automatic test_first_write;
    int cs[6] = '{26, 29, 30, 32, 38, 44};
    logic [3:0] ed[6] = '{4'hE, 4'hE, 4'hF, 4'hD, 4'hB, 4'h7};
    logic [6:0] es[6] = '{7'h01, 7'h01, 7'h7F, 7'h4F, 7'h12, 7'h06};
    wait_cyc(1);
    wr_valid = 1'b1;
    wr_data  = 16'h3210;
    wr_mask  = 4'h0;
    wait_cyc(2);
    wr_valid = 1'b0;
    n_chk++;
    if (wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wr1_ready_c2: got %b want 0", wr_ready);
    end
    wait_cyc(3);
    wr_valid = 1'b1;
    wr_data  = 16'hFFFF;
    for (int c = 3; c < 24; c++) begin
      wait_cyc(c);
      n_chk++;
      if ({seg, dig_sel, wr_ready, frame_done} !== {7'h7F, 4'hF, 2'b00}) begin
        n_fail++;
        $display("FAIL dark_frame c%0d: got seg=%h dig=%h rdy=%b fd=%b want 7f f 0 0",
                 c, seg, dig_sel, wr_ready, frame_done);
      end
    end
    wait_cyc(24);
    n_chk++;
    if ({frame_done, wr_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL boundary24: got fd=%b rdy=%b want 1 0", frame_done, wr_ready);
    end
    wait_cyc(25);
    n_chk++;
    if ({frame_done, wr_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL ready25: got fd=%b rdy=%b want 0 1", frame_done, wr_ready);
    end
    wait_cyc(26);
    wr_valid = 1'b0;
    n_chk++;
    if (wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL held_accept_c26: got rdy=%b want 0", wr_ready);
    end
    for (int i = 0; i < 6; i++) begin
      wait_cyc(cs[i]);
      n_chk++;
      if ({dig_sel, seg} !== {ed[i], es[i]}) begin
        n_fail++;
        $display("FAIL frame1 c%0d: got dig=%h seg=%h want %h %h",
                 cs[i], dig_sel, seg, ed[i], es[i]);
      end
    end
  endtask

  task automatic test_held_write;
    int cs[4] = '{50, 56, 62, 68};
    logic [3:0] ed[4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    wait_cyc(47);
    n_chk++;
    if (frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL fd47: got %b want 0", frame_done);
    end
    wait_cyc(48);
    n_chk++;
    if ({frame_done, wr_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL boundary48: got fd=%b rdy=%b want 1 0", frame_done, wr_ready);
    end
    wait_cyc(49);
    n_chk++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready49: got %b want 1", wr_ready);
    end
    for (int i = 0; i < 4; i++) begin
      wait_cyc(cs[i]);
      n_chk++;
      if ({dig_sel, seg} !== {ed[i], 7'h38}) begin
        n_fail++;
        $display("FAIL held_frame c%0d: got dig=%h seg=%h want %h 38",
                 cs[i], dig_sel, seg, ed[i]);
      end
    end
  endtask

  task automatic test_mask;
    int cs[6] = '{74, 80, 84, 86, 89, 92};
    logic [3:0] ed[6] = '{4'hE, 4'hD, 4'hF, 4'hF, 4'hF, 4'h7};
    logic [6:0] es[6] = '{7'h00, 7'h00, 7'h7F, 7'h7F, 7'h7F, 7'h00};
    wait_cyc(70);
    wr_valid = 1'b1;
    wr_data  = 16'h8888;
    wr_mask  = 4'b0100;
    wait_cyc(71);
    wr_valid = 1'b0;
    wr_mask  = 4'h0;
    n_chk++;
    if (wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mask_accept: got rdy=%b want 0", wr_ready);
    end
    for (int i = 0; i < 6; i++) begin
      wait_cyc(cs[i]);
      n_chk++;
      if ({dig_sel, seg} !== {ed[i], es[i]}) begin
        n_fail++;
        $display("FAIL mask_frame c%0d: got dig=%h seg=%h want %h %h",
                 cs[i], dig_sel, seg, ed[i], es[i]);
      end
    end
  endtask

  task automatic test_boundary_write;
    int cs[4] = '{122, 128, 134, 140};
    logic [3:0] ed[4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] es[4] = '{7'h4C, 7'h08, 7'h04, 7'h30};
    wait_cyc(96);
    n_chk++;
    if ({frame_done, wr_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL boundary96: got fd=%b rdy=%b want 1 1", frame_done, wr_ready);
    end
    wr_valid = 1'b1;
    wr_data  = 16'hE9A4;
    wait_cyc(97);
    wr_valid = 1'b0;
    n_chk++;
    if (wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bnd_accept: got rdy=%b want 0", wr_ready);
    end
    wait_cyc(98);
    n_chk++;
    if ({dig_sel, seg} !== {4'hE, 7'h00}) begin
      n_fail++;
      $display("FAIL bnd_not_early: got dig=%h seg=%h want e 00", dig_sel, seg);
    end
    wait_cyc(121);
    n_chk++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready121: got %b want 1", wr_ready);
    end
    for (int i = 0; i < 4; i++) begin
      wait_cyc(cs[i]);
      n_chk++;
      if ({dig_sel, seg} !== {ed[i], es[i]}) begin
        n_fail++;
        $display("FAIL bnd_frame c%0d: got dig=%h seg=%h want %h %h",
                 cs[i], dig_sel, seg, ed[i], es[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int cs[4] = '{50, 56, 62, 68};
    logic [3:0] ed[4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] es[4] = '{7'h71, 7'h42, 7'h20, 7'h0F};
    wait_cyc(146);
    wr_valid = 1'b1;
    wr_data  = 16'h1111;
    wait_cyc(147);
    wr_valid = 1'b0;
    wait_cyc(153);
    n_chk++;
    if ({dig_sel, seg, wr_ready} !== {4'hD, 7'h08, 1'b0}) begin
      n_fail++;
      $display("FAIL pre_rst: got dig=%h seg=%h rdy=%b want d 08 0",
               dig_sel, seg, wr_ready);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if ({seg, dig_sel, wr_ready, frame_done} !== {7'h7F, 4'hF, 2'b10}) begin
      n_fail++;
      $display("FAIL mid_rst: got seg=%h dig=%h rdy=%b fd=%b want 7f f 1 0",
               seg, dig_sel, wr_ready, frame_done);
    end
    wait_cyc(3);
    n_chk++;
    if ({seg, dig_sel} !== {7'h7F, 4'hF}) begin
      n_fail++;
      $display("FAIL rst_dark3: got seg=%h dig=%h want 7f f", seg, dig_sel);
    end
    wait_cyc(23);
    n_chk++;
    if (frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_fd23: got %b want 0", frame_done);
    end
    wait_cyc(24);
    n_chk++;
    if (frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_fd24: got %b want 1", frame_done);
    end
    wait_cyc(26);
    n_chk++;
    if ({seg, dig_sel, wr_ready} !== {7'h7F, 4'hF, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_discard: got seg=%h dig=%h rdy=%b want 7f f 1",
               seg, dig_sel, wr_ready);
    end
    wr_valid = 1'b1;
    wr_data  = 16'h76DC;
    wait_cyc(27);
    wr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_cyc(cs[i]);
      n_chk++;
      if ({dig_sel, seg} !== {ed[i], es[i]}) begin
        n_fail++;
        $display("FAIL post_rst c%0d: got dig=%h seg=%h want %h %h",
                 cs[i], dig_sel, seg, ed[i], es[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_write();
    test_held_write();
    test_mask();
    test_boundary_write();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-select 7-segment digits that share one segment bus and one hex-to-segment decoder.
- Accepts a full frame of hex nibbles plus a per-digit blank mask through a valid/ready handshake into a pending buffer.
- Swaps the pending buffer into the active buffer only at frame boundaries, so a frame is never torn.
- Cycles the digit select with an inter-digit blanking gap to suppress ghosting.
- Sits between the display-update logic (e.g. encoder result formatting) and the board segment/select pins.

Parameters:
NUM_DIGITS, 8, number of scanned digits (>=2)
DIV, 50000, clock cycles each digit is lit per slot (>=1)
BLANK, 16, clock cycles of all-off gap before each digit slot (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
wr_valid  input  1  frame update offered
wr_ready  output  1  pending buffer free; update accepted when wr_valid && wr_ready
wr_data  input  4*NUM_DIGITS  nibble k (bits 4k+3:4k) is the hex value for digit k
wr_mask  input  NUM_DIGITS  bit k = 1 blanks digit k
seg  output  7  segment drive, active-low, bit6=a ... bit0=g
dig_sel  output  NUM_DIGITS  digit select, active-low one-hot, all-ones = none
frame_done  output  1  one-cycle pulse at each frame boundary

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: seg=7'h7F, dig_sel=all ones, wr_ready=1, frame_done=0. Internal: active data=0, active mask=all ones (display dark), pending empty, digit index=0, state BLANK, counter=0.
- Timing reference: cycle 0 is the first cycle with rst low. Slot period P=BLANK+DIV; frame length F=NUM_DIGITS*P.
- FSM states:
  - BLANK: seg=7F, dig_sel all ones. Lasts BLANK cycles, then goes to SHOW.
  - SHOW: dig_sel bit idx=0, others 1. seg=~LUT(active nibble idx), or 7F with dig_sel all ones if active mask bit idx=1. Lasts DIV cycles.
  - Leaving SHOW: idx increments, wrapping from NUM_DIGITS-1 to 0, then back to BLANK.
- Output window: digit k is driven during cycles [n*F+k*P+BLANK, n*F+(k+1)*P).
- Masking does not alter slot timing.
- Handshake:
  - Transfer occurs when wr_valid && wr_ready on a rising edge; wr_data and wr_mask are captured into pending.
  - wr_ready drops the next cycle and stays low while pending is full.
  - Upstream holds valid and data stable while ready is low; no bypass to the active buffer.
- Frame boundary: cycles n*F for n>=1, i.e. entry into digit-0 BLANK after digit NUM_DIGITS-1 SHOW. At a boundary:
  - frame_done=1 for that cycle.
  - If pending is full, it is copied to active (visible from digit-0 SHOW) and wr_ready returns to 1 on the following cycle.
  - A handshake in the boundary cycle is captured into pending and is applied at the next boundary only.
- Counters: slot counter width $clog2(max(DIV,BLANK)); idx width $clog2(NUM_DIGITS). No overflow past terminal counts.
- Reset mid-operation: outputs return to reset values the cycle after rst is sampled high. Pending and active contents are discarded and timing restarts at cycle 0 after release.

Decomposition:
- Package seg_pkg holds:
  - active-high segment constants, a..g order: 0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70 8:7F 9:7B A:77 b:1F c:0E d:3D E:4F F:47
  - SEG_OFF=7'h7F
  - scan state enum {BLANK, SHOW}
- Sub-module hex7seg_lut: combinational 4-bit in, active-low 7-bit out, using the package table. Instantiated once and shared across digits.

Test Plan:
(bench: NUM_DIGITS=4, DIV=4, BLANK=2, so P=6, F=24)
1. Reset held 3 cycles then released -> seg=7F, dig_sel=F, wr_ready=1. seg stays 7F for the whole first frame. frame_done pulses at cycles 24, 48.
2. Cycle 1: wr_valid, wr_data=16'h3210, wr_mask=0 -> wr_ready=0 from cycle 2 to cycle 24; wr_ready=1 at cycle 25. Cycles 26-29: dig_sel=E, seg=01. Cycles 32-35: dig_sel=D, seg=4F. Cycles 44-47: dig_sel=7, seg=06.
3. Second write (16'hFFFF) offered at cycle 3 and held -> accepted at cycle 25, shown from cycle 50: seg=38 in all four slots.
4. wr_mask=4'b0100 with data 16'h8888 -> slot 2 shows seg=7F, dig_sel=F. Other slots show seg=00 at unchanged timing.
5. Write offered exactly in boundary cycle 24 with pending empty -> accepted at 24, frame_done=1. Not shown in frame starting at 24; shown from cycle 50.
6. rst pulsed high in cycle 33 (digit-1 SHOW) -> cycle 34: seg=7F, dig_sel=F, wr_ready=1. Display dark until new write; after release, frame_done next at 24 cycles after release.
